// File: rtl/alu16_seq.sv
// 16-bit add sequencer over the 8-bit ALU: low-byte ADD then high-byte ADC, composes result and Z/N/H/C.
// Optional INC16/DEC16 via the ALU 16-bit path when ALU16_INCDEC_EN is defined; otherwise they pass opnd_x through.
package alu16_pkg;
   typedef enum logic [3:0] {
      alu_NOP  = 4'd0,
      alu_ADD  = 4'd1,
      alu_ADC  = 4'd2,
      alu_INCL = 4'd3,
      alu_DECL = 4'd4
   } alu_op_t;
endpackage

module alu16_seq (
   input  logic               clk,
   input  logic               rst_b,
   input  logic               start,
   input  logic [1:0]         op_sel,
   input  logic [15:0]        opnd_x,
   input  logic [15:0]        opnd_y,
   input  logic [3:0]         flags_in,
   output logic               busy,
   output logic               done,
   output logic [15:0]        result,
   output logic [3:0]         flags_out,
   output logic [7:0]         alu_op_A,
   output logic [7:0]         alu_op_B,
   output alu16_pkg::alu_op_t alu_op_code,
   output logic [3:0]         alu_curr_flags,
   input  logic [7:0]         alu_result,
   input  logic [3:0]         alu_next_flags,
   input  logic [15:0]        alu_addr_result
);
   import alu16_pkg::*;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOW  = 2'd1;
   localparam logic [1:0] S_HIGH = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OP_ADD_SP = 2'b01;

`ifdef ALU16_INCDEC_EN
   localparam bit INCDEC_EN = 1'b1;
`else
   localparam bit INCDEC_EN = 1'b0;
`endif

   logic [1:0]  state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic [3:0]  fl_q, fl_d;
   logic [7:0]  res_lo_q, res_lo_d;
   logic        c_lo_q, c_lo_d;
   logic        h_lo_q, h_lo_d;
   logic [15:0] result_q, result_d;
   logic [3:0]  flags_q, flags_d;

   // Z and N from the ALU are never needed; Z comes from the latched flags.
   logic unused_alu_zn;
   assign unused_alu_zn = ^alu_next_flags[3:2];

   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      x_d            = x_q;
      y_d            = y_q;
      fl_d           = fl_q;
      res_lo_d       = res_lo_q;
      c_lo_d         = c_lo_q;
      h_lo_d         = h_lo_q;
      result_d       = result_q;
      flags_d        = flags_q;
      alu_op_A       = 8'h00;
      alu_op_B       = 8'h00;
      alu_op_code    = alu_NOP;
      alu_curr_flags = flags_in;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d = op_sel;
               x_d  = opnd_x;
               y_d  = opnd_y;
               fl_d = flags_in;
               if (op_sel[1] && !INCDEC_EN) begin
                  // No 16-bit ALU path available: INC16/DEC16 degrade to a pass-through.
                  result_d = opnd_x;
                  flags_d  = flags_in;
                  state_d  = S_DONE;
               end else begin
                  state_d = S_LOW;
               end
            end
         end
         S_LOW: begin
            alu_curr_flags = fl_q;
            if (op_q[1]) begin
               alu_op_A    = x_q[15:8];
               alu_op_B    = x_q[7:0];
               alu_op_code = op_q[0] ? alu_DECL : alu_INCL;
               result_d    = alu_addr_result;
               flags_d     = fl_q;
               state_d     = S_DONE;
            end else begin
               alu_op_A    = x_q[7:0];
               alu_op_B    = y_q[7:0];
               alu_op_code = alu_ADD;
               res_lo_d    = alu_result;
               c_lo_d      = alu_next_flags[0];
               h_lo_d      = alu_next_flags[1];
               state_d     = S_HIGH;
            end
         end
         S_HIGH: begin
            alu_op_A       = x_q[15:8];
            alu_op_B       = (op_q == OP_ADD_SP) ? {8{y_q[7]}} : y_q[15:8];
            alu_op_code    = alu_ADC;
            alu_curr_flags = {fl_q[3:1], c_lo_q};
            result_d       = {alu_result, res_lo_q};
            // SP+e8 reports the unsigned low-byte carries; HL+rr reports bit-11/bit-15 carries.
            if (op_q == OP_ADD_SP) flags_d = {2'b00, h_lo_q, c_lo_q};
            else                   flags_d = {fl_q[3], 1'b0, alu_next_flags[1], alu_next_flags[0]};
            state_d        = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= S_IDLE;
         op_q     <= 2'b00;
         x_q      <= 16'h0000;
         y_q      <= 16'h0000;
         fl_q     <= 4'h0;
         res_lo_q <= 8'h00;
         c_lo_q   <= 1'b0;
         h_lo_q   <= 1'b0;
         result_q <= 16'h0000;
         flags_q  <= 4'h0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         x_q      <= x_d;
         y_q      <= y_d;
         fl_q     <= fl_d;
         res_lo_q <= res_lo_d;
         c_lo_q   <= c_lo_d;
         h_lo_q   <= h_lo_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign busy      = (state_q == S_LOW) || (state_q == S_HIGH);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign flags_out = flags_q;
endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq: behavioural 8-bit ALU stub, 16-bit reference model, scoreboard queue and done monitor.
`timescale 1ns/1ps
module tb_alu16_seq;
   import alu16_pkg::*;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        start;
   logic [1:0]  op_sel;
   logic [15:0] opnd_x, opnd_y;
   logic [3:0]  flags_in;
   logic        busy, done;
   logic [15:0] result;
   logic [3:0]  flags_out;
   logic [7:0]  alu_op_A, alu_op_B;
   alu_op_t     alu_op_code;
   logic [3:0]  alu_curr_flags;
   logic [7:0]  alu_result;
   logic [3:0]  alu_next_flags;
   logic [15:0] alu_addr_result;

   always #5 clk = ~clk;

   alu16_seq dut (
      .clk(clk), .rst_b(rst_b), .start(start), .op_sel(op_sel),
      .opnd_x(opnd_x), .opnd_y(opnd_y), .flags_in(flags_in),
      .busy(busy), .done(done), .result(result), .flags_out(flags_out),
      .alu_op_A(alu_op_A), .alu_op_B(alu_op_B), .alu_op_code(alu_op_code),
      .alu_curr_flags(alu_curr_flags), .alu_result(alu_result),
      .alu_next_flags(alu_next_flags), .alu_addr_result(alu_addr_result)
   );

   // 8-bit ALU stand-in
   logic [8:0] alu_sum;
   logic       alu_h;
   always_comb begin
      alu_sum         = 9'd0;
      alu_h           = 1'b0;
      alu_addr_result = 16'h0000;
      case (alu_op_code)
         alu_ADD: begin
            alu_sum = {1'b0, alu_op_A} + {1'b0, alu_op_B};
            alu_h   = ({1'b0, alu_op_A[3:0]} + {1'b0, alu_op_B[3:0]}) > 5'd15;
         end
         alu_ADC: begin
            alu_sum = {1'b0, alu_op_A} + {1'b0, alu_op_B} + {8'd0, alu_curr_flags[0]};
            alu_h   = ({1'b0, alu_op_A[3:0]} + {1'b0, alu_op_B[3:0]} + {4'd0, alu_curr_flags[0]}) > 5'd15;
         end
         alu_INCL: alu_addr_result = {alu_op_A, alu_op_B} + 16'd1;
         alu_DECL: alu_addr_result = {alu_op_A, alu_op_B} - 16'd1;
         default: ;
      endcase
   end
   assign alu_result     = alu_sum[7:0];
   assign alu_next_flags = {alu_sum[7:0] == 8'h00, 1'b0, alu_h, alu_sum[8]};

   typedef struct {
      logic [15:0] res;
      logic [3:0]  fl;
      int          lat;
      int          issue;
      string       name;
   } exp_t;

   exp_t sbq[$];
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Whole-word reference: 16-bit sums with carries taken from masked partial sums.
   function automatic void ref_model(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                                     input logic [3:0] f, output logic [15:0] r,
                                     output logic [3:0] fo, output int lat);
      int e;
      case (op)
         2'b00: begin
            r   = 16'(int'(x) + int'(y));
            fo  = {f[3], 1'b0, (int'(x[11:0]) + int'(y[11:0])) > 4095, (int'(x) + int'(y)) > 65535};
            lat = 3;
         end
         2'b01: begin
            e   = y[7] ? int'(y[7:0]) - 256 : int'(y[7:0]);
            r   = 16'(int'(x) + e);
            fo  = {2'b00, (int'(x[3:0]) + int'(y[3:0])) > 15, (int'(x[7:0]) + int'(y[7:0])) > 255};
            lat = 3;
         end
         default: begin
`ifdef ALU16_INCDEC_EN
            r   = op[0] ? 16'(int'(x) - 1) : 16'(int'(x) + 1);
            fo  = f;
            lat = 2;
`else
            r   = x;
            fo  = f;
            lat = 1;
`endif
         end
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_b === 1'b1 && done === 1'b1) begin
         done_cnt++;
         if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: got done=1 with result %0h, expected no completion", result);
         end else begin
            e = sbq.pop_front();
            check({e.name, "_result"}, 32'(result), 32'(e.res));
            check({e.name, "_flags"}, 32'(flags_out), 32'(e.fl));
            check({e.name, "_latency"}, 32'(cyc - e.issue + 1), 32'(e.lat));
            check({e.name, "_busy_at_done"}, 32'(busy), 32'd0);
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y,
                        input logic [3:0] f, input string nm);
      exp_t e;
      @(negedge clk);
      start = 1'b1; op_sel = op; opnd_x = x; opnd_y = y; flags_in = f;
      ref_model(op, x, y, f, e.res, e.fl, e.lat);
      e.name = nm;
      @(posedge clk);
      #1;
      e.issue = cyc;
      sbq.push_back(e);
      start = 1'b0;
   endtask

   // Waits for done (bounded); optionally scrambles inputs and random start while busy.
   task automatic wait_done(input string nm, input bit scramble);
      bit seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (scramble) begin
            start    = 1'($urandom);
            op_sel   = 2'($urandom);
            opnd_x   = 16'($urandom);
            opnd_y   = 16'($urandom);
            flags_in = 4'($urandom);
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_chk++;
         $display("FAIL %s_timeout: got no done within 12 cycles, expected done", nm);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int d0;
      rst_b = 1'b0; start = 1'b0; op_sel = 2'b00;
      opnd_x = 16'h0; opnd_y = 16'h0; flags_in = 4'h0;
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", 32'(result), 32'd0);
      check("reset_flags", 32'(flags_out), 32'd0);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;

      // HL wrap-around with a second start held high through LOW/HIGH/DONE
      issue(2'b00, 16'h8FFF, 16'h7001, 4'b1000, "hl_wrap");
      d0 = done_cnt;
      start = 1'b1; opnd_x = 16'h1234; opnd_y = 16'h1111;
      wait_done("hl_wrap", 1'b0);
      repeat (4) @(negedge clk);
      check("hl_wrap_single_done", 32'(done_cnt - d0), 32'd1);

      // SP + negative e8; high byte must add the sign extension
      issue(2'b01, 16'h0005, 16'h00FF, 4'b0000, "sp_neg");
      @(negedge clk);
      check("sp_neg_low_code", 32'(alu_op_code), 32'(alu_ADD));
      check("sp_neg_low_B", 32'(alu_op_B), 32'h00FF);
      @(negedge clk);
      check("sp_neg_high_code", 32'(alu_op_code), 32'(alu_ADC));
      check("sp_neg_high_B", 32'(alu_op_B), 32'h00FF);
      wait_done("sp_neg", 1'b0);

      issue(2'b01, 16'hFFF8, 16'h0008, 4'b1000, "sp_pos");
      wait_done("sp_pos", 1'b0);

      issue(2'b10, 16'hFFFF, 16'h0000, 4'b0110, "inc16");
      wait_done("inc16", 1'b0);

      // Leave non-zero result/flags, then reset in the middle of HIGH
      issue(2'b00, 16'h1234, 16'h1111, 4'b1111, "pre_rst");
      wait_done("pre_rst", 1'b0);
      issue(2'b00, 16'h1111, 16'h2222, 4'b0000, "aborted");
      @(negedge clk);
      @(negedge clk);
      check("abort_in_high", 32'(alu_op_code), 32'(alu_ADC));
      rst_b = 1'b0;
      sbq.delete();
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_result", 32'(result), 32'd0);
      check("mid_rst_flags", 32'(flags_out), 32'd0);
      @(negedge clk);
      rst_b = 1'b1;
      issue(2'b00, 16'h0001, 16'h0001, 4'b0000, "post_rst");
      wait_done("post_rst", 1'b0);

      for (int i = 0; i < 40; i++) begin
         issue(2'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), $sformatf("rnd%0d", i));
         wait_done($sformatf("rnd%0d", i), 1'b1);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
